// File: rtl/snake_pkg.sv
// Shared constants, FSM state type and speed encoding for the snake display step sequencer.
package snake_pkg;

  localparam int STEP_W = 5;
  localparam int STEPS  = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
  } state_e;

  typedef enum logic [1:0] {
    SPD_X1 = 2'd0,
    SPD_X2 = 2'd1,
    SPD_X4 = 2'd2,
    SPD_X8 = 2'd3
  } speed_e;

  // Right-shift applied to the base divider; each speed step halves the advance period.
  function automatic logic [1:0] speed_shift(input logic [1:0] speed);
    logic [1:0] sh;
    case (speed_e'(speed))
      SPD_X1:  sh = 2'd0;
      SPD_X2:  sh = 2'd1;
      SPD_X4:  sh = 2'd2;
      SPD_X8:  sh = 2'd3;
      default: sh = 2'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Period counter for the snake sequencer: counts while enabled and flags the terminal cycle.
module tick_prescaler #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a shortened period mid-count terminates at once instead of wrapping.
  assign tc = en && (cnt >= (period - CNT_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Run/pause/single-step sequencer producing the snake display step index.
// Define SNAKE_LAP_EN to build the lap_cnt output and its lap register.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int STEPS    = snake_pkg::STEPS,
  parameter int TICK_DIV = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_btn,
  input  logic              clr,
  input  logic              dir,
  input  logic [1:0]        speed,
  output logic [STEP_W-1:0] step,
  output logic              tick,
  output logic              running
`ifdef SNAKE_LAP_EN
  ,
  output logic [7:0]        lap_cnt
`endif
);

  localparam int                CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [STEP_W-1:0] LAST  = STEP_W'(STEPS - 1);

  state_e            state_q, state_d;
  logic              enter_run;
  logic              btn_adv;
  logic              advance;
  logic              tc;
  logic              wrap;
  logic [STEP_W-1:0] step_nxt;
  logic [CNT_W-1:0]  period;

  assign period = CNT_W'(TICK_DIV >> speed_shift(speed));

  tick_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == S_RUN),
    .clr    (clr || enter_run),
    .period (period),
    .tc     (tc)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    btn_adv   = 1'b0;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        // A run rise wins over a coincident button press.
        if (run) begin
          state_d   = S_RUN;
          enter_run = 1'b1;
        end else if (step_btn) begin
          btn_adv = 1'b1;
        end
      end
      S_RUN: begin
        if (!run) state_d = S_PAUSE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d   = S_IDLE;
      enter_run = 1'b0;
      btn_adv   = 1'b0;
    end
  end

  assign advance = !clr && (tc || btn_adv);

  always_comb begin
    wrap = dir ? (step == '0) : (step == LAST);
    if (dir) step_nxt = wrap ? LAST : step - STEP_W'(1);
    else     step_nxt = wrap ? '0   : step + STEP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step    <= '0;
      tick    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick    <= advance;
      if (clr)          step <= '0;
      else if (advance) step <= step_nxt;
    end
  end

  assign running = (state_q == S_RUN);

`ifdef SNAKE_LAP_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lap_cnt <= '0;
    end else if (advance && wrap) begin
      lap_cnt <= lap_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl with TICK_DIV=8 (periods 8/4/2/1).
module tb_snake_step_ctrl;

  localparam int TD    = 8;
  localparam int NSTEP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step_btn = 1'b0;
  logic       clr = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [4:0] step;
  logic       tick;
  logic       running;
`ifdef SNAKE_LAP_EN
  logic [7:0] lap_cnt;
`endif

  snake_step_ctrl #(.STEPS(NSTEP), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step_btn (step_btn),
    .clr      (clr),
    .dir      (dir),
    .speed    (speed),
    .step     (step),
    .tick     (tick),
    .running  (running)
`ifdef SNAKE_LAP_EN
    ,
    .lap_cnt  (lap_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int tick;
    int running;
    int lap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: 0 idle, 1 run, 2 pause.
  int m_state = 0;
  int m_cnt   = 0;
  int m_step  = 0;
  int m_lap   = 0;
  int m_tick  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_eval(output exp_t e);
    int period;
    int adv;
    period = TD >> speed;
    adv    = 0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_step = 0; m_lap = 0; m_tick = 0;
    end else if (clr) begin
      m_state = 0; m_cnt = 0; m_step = 0; m_lap = 0; m_tick = 0;
    end else begin
      if (m_state == 1) begin
        if (m_cnt >= period - 1) begin
          adv   = 1;
          m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
        if (!run) m_state = 2;
      end else begin
        if (run) begin
          m_state = 1;
          m_cnt   = 0;
        end else if (step_btn) begin
          adv = 1;
        end
      end
      if (adv) begin
        if (!dir) begin
          if (m_step == NSTEP - 1) begin m_step = 0; m_lap = (m_lap + 1) % 256; end
          else m_step = m_step + 1;
        end else begin
          if (m_step == 0) begin m_step = NSTEP - 1; m_lap = (m_lap + 1) % 256; end
          else m_step = m_step - 1;
        end
      end
      m_tick = adv;
    end
    e.step    = m_step;
    e.tick    = m_tick;
    e.running = (m_state == 1) ? 1 : 0;
    e.lap     = m_lap;
  endtask

  task automatic do_cycle(input bit b, input bit c);
    exp_t e;
    step_btn = b;
    clr      = c;
    model_eval(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("step", int'(step), e.step);
    check("tick", int'(tick), e.tick);
    check("running", int'(running), e.running);
`ifdef SNAKE_LAP_EN
    check("lap_cnt", int'(lap_cnt), e.lap);
`endif
    step_btn = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      do_cycle(1'b0, 1'b0);
      n++;
    end while (!tick && n < 64);
    if (!tick) check("tick_timeout", 0, 1);
  endtask

  initial begin
    int n;

    // 1. reset, then forward run at speed 0
    rst = 1'b1;
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b0);
    rst = 1'b0;
    check("rst_step", int'(step), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_running", int'(running), 0);
    run = 1'b1;
    do_cycle(1'b0, 1'b0);
    check("run_entry", int'(running), 1);
    for (int i = 0; i < NSTEP; i++) begin
      wait_tick(n);
      check("period_s0", n, 8);
      check("fwd_step", int'(step), (i + 1) % NSTEP);
    end

    // 2. reverse wrap from 0
`ifdef SNAKE_LAP_EN
    check("lap_fwd", int'(lap_cnt), 1);
`endif
    dir = 1'b1;
    wait_tick(n);
    check("rev_wrap", int'(step), NSTEP - 1);
`ifdef SNAKE_LAP_EN
    check("lap_rev", int'(lap_cnt), 2);
`endif

    // 3. speed raised mid-count (cnt=6), then fastest
    repeat (6) do_cycle(1'b0, 1'b0);
    speed = 2'd2;
    wait_tick(n);
    check("speed_up_immediate", n, 1);
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      check("period_s2", n, 2);
    end
    speed = 2'd3;
    for (int i = 0; i < 2; i++) begin
      wait_tick(n);
      check("period_s3", n, 1);
    end

    // 4. pause at step 5, single steps, resume
    speed = 2'd0;
    dir   = 1'b0;
    for (int i = 0; i < 40 && step != 5; i++) wait_tick(n);
    check("reach_5", int'(step), 5);
    run = 1'b0;
    do_cycle(1'b0, 1'b0);
    check("pause_running", int'(running), 0);
    repeat (2) do_cycle(1'b0, 1'b0);
    check("pause_hold", int'(step), 5);
    for (int k = 0; k < 3; k++) begin
      do_cycle(1'b1, 1'b0);
      check("btn_step", int'(step), 6 + k);
      check("btn_tick", int'(tick), 1);
    end
    do_cycle(1'b0, 1'b0);
    check("btn_tick_off", int'(tick), 0);
    run = 1'b1;
    do_cycle(1'b0, 1'b0);
    wait_tick(n);
    check("resume_period", n, 8);
    check("resume_step", int'(step), 9);

    // 5. clr at step 12, then rst with step_btn
    for (int i = 0; i < 10 && step != 12; i++) wait_tick(n);
    repeat (3) do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b1);
    check("clr_step", int'(step), 0);
    check("clr_tick", int'(tick), 0);
    check("clr_running", int'(running), 0);
    run = 1'b0;
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b0);
    check("idle_btn", int'(step), 1);
    rst = 1'b1;
    do_cycle(1'b1, 1'b0);
    check("rst_btn_step", int'(step), 0);
    check("rst_btn_tick", int'(tick), 0);
    rst = 1'b0;

    // 6. run rise with step_btn while paused
    run = 1'b1;
    do_cycle(1'b0, 1'b0);
    run = 1'b0;
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b1, 1'b0);
    check("pause_btn", int'(step), 1);
    run = 1'b1;
    do_cycle(1'b1, 1'b0);
    check("rise_btn_step", int'(step), 1);
    check("rise_btn_tick", int'(tick), 0);
    check("rise_btn_running", int'(running), 1);
    wait_tick(n);
    check("rise_period", n, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
